// File: rtl/digdug_pkg.sv
// Shared constants and types for the sprite attribute table block.
//   SPAT_AW / SPAT_DW : table address width and entry width
//   LANE0..LANE2      : CPU bank codes selecting byte lanes 7:0, 15:8, 23:16
//   BANK_INVALID      : bank code with no backing lane (writes dropped, reads 8'hFF)
//   copy_state_e      : VBLANK copy engine states
package digdug_pkg;

   localparam int unsigned SPAT_AW    = 7;
   localparam int unsigned SPAT_DW    = 24;
   localparam int unsigned SPAT_LANES = 3;
   localparam int unsigned SPAT_LW    = 8;

   localparam logic [1:0] LANE0        = 2'd0;
   localparam logic [1:0] LANE1        = 2'd1;
   localparam logic [1:0] LANE2        = 2'd2;
   localparam logic [1:0] BANK_INVALID = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COPY  = 2'd1,
      FLUSH = 2'd2
   } copy_state_e;

   // Byte-lane write enables for a CPU bank code; the invalid bank enables nothing.
   function automatic logic [SPAT_LANES-1:0] lane_be(input logic [1:0] bank);
      logic [SPAT_LANES-1:0] be;
      be = '0;
      case (bank)
         LANE0:   be = 3'b001;
         LANE1:   be = 3'b010;
         LANE2:   be = 3'b100;
         default: be = 3'b000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sprite_attr_dpram.sv
// Simple dual-port RAM, read-first, with byte-lane write enables.
//   CLK, RESET : clock and synchronous active-high reset (clears read registers only)
//   addr_a     : port A address (write and registered read)
//   be_a       : port A per-lane write enables
//   wdata_a    : port A write data
//   rdata_a    : port A registered read data (old contents on same-cycle write)
//   addr_b     : port B read address
//   rdata_b    : port B registered read data (old contents on same-cycle write)
module sprite_attr_dpram #(
   parameter int unsigned AW    = 7,
   parameter int unsigned DW    = 24,
   parameter int unsigned LANES = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [AW-1:0]    addr_a,
   input  logic [LANES-1:0] be_a,
   input  logic [DW-1:0]    wdata_a,
   output logic [DW-1:0]    rdata_a,
   input  logic [AW-1:0]    addr_b,
   output logic [DW-1:0]    rdata_b
);

   localparam int unsigned LW = DW / LANES;

   logic [DW-1:0] mem [0:(2**AW)-1];

   // Storage has no reset: table contents survive RESET.
   always_ff @(posedge CLK) begin
      for (int l = 0; l < LANES; l++) begin
         if (be_a[l]) begin
            mem[addr_a][l*LW +: LW] <= wdata_a[l*LW +: LW];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         rdata_a <= mem[addr_a];
         rdata_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/digdug_sprite_attr_ram.sv
// Sprite attribute table responder: CPU-written shadow table, snapshotted into a
// render table on each VBLANK rising edge so the renderer sees a frame-coherent table.
//   CLK, RESET : clock and synchronous active-high reset
//   CPUAD      : [AW+1:AW] bank/lane, [AW-1:0] entry
//   CPUWE      : CPU byte write strobe
//   CPUDI      : CPU write data
//   CPUDO      : CPU readback of shadow byte, 1-cycle latency, 8'hFF for bank 3
//   VBLANK     : vertical blank level
//   SPATAD     : renderer entry address
//   SPATDT     : renderer entry data, 1-cycle latency
//   BUSY       : copy in progress
//   DONE       : one-cycle pulse after the last render write
module digdug_sprite_attr_ram
   import digdug_pkg::*;
#(
   parameter int unsigned AW      = SPAT_AW,
   parameter bit          COPY_EN = 1'b1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [AW+1:0]       CPUAD,
   input  logic                CPUWE,
   input  logic [SPAT_LW-1:0]  CPUDI,
   output logic [SPAT_LW-1:0]  CPUDO,
   input  logic                VBLANK,
   input  logic [AW-1:0]       SPATAD,
   output logic [SPAT_DW-1:0]  SPATDT,
   output logic                BUSY,
   output logic                DONE
);

   logic [1:0]            cpu_bank;
   logic [AW-1:0]         cpu_entry;
   logic [SPAT_LANES-1:0] cpu_be;
   logic [1:0]            bank_q;

   logic [SPAT_DW-1:0]    shadow_rd_a;
   logic [SPAT_DW-1:0]    shadow_rd_b;
   logic [AW-1:0]         shadow_addr_b;

   logic [SPAT_DW-1:0]    render_rd;
   logic [SPAT_DW-1:0]    render_unused_rd;
   logic [AW-1:0]         render_waddr;
   logic [SPAT_LANES-1:0] render_be;
   logic                  copy_we;

   copy_state_e           state_q;
   logic [AW:0]           rdptr_q;
   logic [AW:0]           rdptr_nxt;
   logic                  vblank_q;
   logic                  start;

   assign cpu_bank  = CPUAD[AW+1:AW];
   assign cpu_entry = CPUAD[AW-1:0];
   assign cpu_be    = CPUWE ? lane_be(cpu_bank) : '0;

   assign start     = VBLANK & ~vblank_q;
   assign rdptr_nxt = rdptr_q + 1'b1;

   // Stage 2 of the copy: the shadow word read last cycle lands at rdptr-1.
   // In FLUSH rdptr has reached 2^AW, so the low bits minus one give the last entry.
   assign copy_we      = ((state_q == COPY) && (rdptr_q != '0)) || (state_q == FLUSH);
   assign render_waddr = rdptr_q[AW-1:0] - 1'b1;
   assign render_be    = copy_we ? '1 : '0;

   assign shadow_addr_b = COPY_EN ? rdptr_q[AW-1:0] : SPATAD;

   sprite_attr_dpram #(
      .AW    (AW),
      .DW    (SPAT_DW),
      .LANES (SPAT_LANES)
   ) u_shadow (
      .CLK     (CLK),
      .RESET   (RESET),
      .addr_a  (cpu_entry),
      .be_a    (cpu_be),
      .wdata_a ({SPAT_LANES{CPUDI}}),
      .rdata_a (shadow_rd_a),
      .addr_b  (shadow_addr_b),
      .rdata_b (shadow_rd_b)
   );

   sprite_attr_dpram #(
      .AW    (AW),
      .DW    (SPAT_DW),
      .LANES (SPAT_LANES)
   ) u_render (
      .CLK     (CLK),
      .RESET   (RESET),
      .addr_a  (render_waddr),
      .be_a    (render_be),
      .wdata_a (shadow_rd_b),
      .rdata_a (render_unused_rd),
      .addr_b  (SPATAD),
      .rdata_b (render_rd)
   );

   assign SPATDT = COPY_EN ? render_rd : shadow_rd_b;

   // Bank is registered alongside the RAM read so the lane mux matches the data.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         bank_q <= LANE0;
      end else begin
         bank_q <= cpu_bank;
      end
   end

   always_comb begin
      CPUDO = 8'hFF;
      case (bank_q)
         LANE0:   CPUDO = shadow_rd_a[7:0];
         LANE1:   CPUDO = shadow_rd_a[15:8];
         LANE2:   CPUDO = shadow_rd_a[23:16];
         default: CPUDO = 8'hFF;
      endcase
   end

   // Copy engine; VBLANK edges outside IDLE are ignored so a copy never restarts.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         rdptr_q  <= '0;
         vblank_q <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         vblank_q <= VBLANK;
         DONE     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (COPY_EN && start) begin
                  state_q <= COPY;
                  rdptr_q <= '0;
                  BUSY    <= 1'b1;
               end
            end
            COPY: begin
               rdptr_q <= rdptr_nxt;
               if (rdptr_nxt[AW]) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               state_q <= IDLE;
               rdptr_q <= '0;
               BUSY    <= 1'b0;
               DONE    <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               rdptr_q <= '0;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digdug_sprite_attr_ram.sv
module tb_digdug_sprite_attr_ram;

   logic        CLK;
   logic        RESET;
   logic [8:0]  CPUAD;
   logic        CPUWE;
   logic [7:0]  CPUDI;
   logic [7:0]  CPUDO;
   logic        VBLANK;
   logic [6:0]  SPATAD;
   logic [23:0] SPATDT;
   logic        BUSY;
   logic        DONE;

   int checks = 0;
   int errors = 0;

   digdug_sprite_attr_ram #(
      .AW      (7),
      .COPY_EN (1'b1)
   ) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .CPUAD  (CPUAD),
      .CPUWE  (CPUWE),
      .CPUDI  (CPUDI),
      .CPUDO  (CPUDO),
      .VBLANK (VBLANK),
      .SPATAD (SPATAD),
      .SPATDT (SPATDT),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] data);
      CPUAD = addr;
      CPUDI = data;
      CPUWE = 1'b1;
      tick();
      CPUWE = 1'b0;
   endtask

   task automatic cpu_rd(input string tag, input logic [8:0] addr, input logic [7:0] exp);
      CPUAD = addr;
      tick();
      check(tag, {16'h0, CPUDO}, {16'h0, exp});
   endtask

   task automatic spat_rd(input string tag, input logic [6:0] addr, input logic [23:0] exp);
      SPATAD = addr;
      tick();
      check(tag, SPATDT, exp);
   endtask

   // mode 0: plain copy; 1: CPU writes at rdptr 10/11; 2: second VBLANK at BUSY cycle 50;
   // 3: RESET at BUSY cycle 60; 4: renderer read of the entry being written.
   task automatic run_copy(input int mode, output int nbusy, output int ndone, output int done_s);
      VBLANK = 1'b1;
      tick();
      VBLANK = 1'b0;
      nbusy  = 0;
      ndone  = 0;
      done_s = -1;
      for (int s = 0; s < 200; s++) begin
         if (BUSY) nbusy++;
         if (DONE) begin
            ndone++;
            if (done_s < 0) done_s = s;
         end
         if (mode == 1 && s == 10) begin
            CPUAD = 9'h064;
            CPUDI = 8'h5A;
            CPUWE = 1'b1;
         end
         if (mode == 1 && s == 11) begin
            CPUAD = 9'h003;
            CPUDI = 8'hA5;
         end
         if (mode == 1 && s == 12) CPUWE = 1'b0;
         if (mode == 2 && s == 49) VBLANK = 1'b1;
         if (mode == 2 && s == 52) VBLANK = 1'b0;
         if (mode == 3 && s == 59) RESET = 1'b1;
         if (mode == 3 && s == 60) begin
            check("rst_mid_busy", {23'h0, BUSY}, 24'h0);
            check("rst_mid_spatdt", SPATDT, 24'h0);
            RESET = 1'b0;
         end
         if (mode == 4 && s == 21) SPATAD = 7'd20;
         if (mode == 4 && s == 22) check("render_read_first_old", SPATDT, 24'hD74E14);
         if (mode == 4 && s == 23) check("render_read_first_new", SPATDT, 24'hD74EE4);
         tick();
      end
   endtask

   int nb, nd, ds;
   logic [7:0] e8;

   initial begin
      RESET  = 1'b1;
      CPUAD  = '0;
      CPUWE  = 1'b0;
      CPUDI  = '0;
      VBLANK = 1'b0;
      SPATAD = '0;
      tick();
      tick();
      check("reset_spatdt", SPATDT, 24'h0);
      check("reset_cpudo", {16'h0, CPUDO}, 24'h0);
      check("reset_busy", {23'h0, BUSY}, 24'h0);
      check("reset_done", {23'h0, DONE}, 24'h0);
      RESET = 1'b0;
      tick();

      // Known baseline: entry e = {e^C3, e^5A, e}.
      for (int e = 0; e < 128; e++) begin
         e8 = 8'(e);
         cpu_wr({2'd0, e8[6:0]}, e8);
         cpu_wr({2'd1, e8[6:0]}, e8 ^ 8'h5A);
         cpu_wr({2'd2, e8[6:0]}, e8 ^ 8'hC3);
      end
      cpu_wr(9'h005, 8'h11);
      cpu_wr(9'h085, 8'h22);
      cpu_wr(9'h105, 8'h33);

      cpu_rd("cpu_rd_lane1", 9'h085, 8'h22);
      cpu_wr(9'h185, 8'hAA);
      cpu_rd("cpu_rd_bank3", 9'h185, 8'hFF);
      cpu_rd("cpu_rd_lane0_after_bank3", 9'h005, 8'h11);
      cpu_rd("cpu_rd_lane2_after_bank3", 9'h105, 8'h33);

      run_copy(0, nb, nd, ds);
      check("copy1_busy_cycles", 24'(nb), 24'd129);
      check("copy1_done_count", 24'(nd), 24'd1);
      check("copy1_done_after_busy", 24'(ds), 24'd129);
      spat_rd("copy1_entry5", 7'd5, 24'h332211);
      spat_rd("copy1_entry0", 7'd0, 24'hC35A00);
      spat_rd("copy1_entry127", 7'd127, 24'hBC257F);

      cpu_wr(9'h005, 8'h44);
      repeat (3) tick();
      spat_rd("no_vblank_entry5", 7'd5, 24'h332211);

      run_copy(1, nb, nd, ds);
      check("copy2_busy_cycles", 24'(nb), 24'd129);
      check("copy2_done_count", 24'(nd), 24'd1);
      spat_rd("copy2_entry5", 7'd5, 24'h332244);
      spat_rd("copy2_entry100_unread_write", 7'd100, 24'hA73E5A);
      spat_rd("copy2_entry3_read_already", 7'd3, 24'hC05903);

      run_copy(2, nb, nd, ds);
      check("copy3_busy_no_restart", 24'(nb), 24'd129);
      check("copy3_single_done", 24'(nd), 24'd1);
      check("copy3_done_after_busy", 24'(ds), 24'd129);
      spat_rd("copy3_entry3", 7'd3, 24'hC059A5);

      cpu_wr(9'h000, 8'hE0);
      cpu_wr(9'h03A, 8'hE1);
      cpu_wr(9'h03C, 8'hE2);
      cpu_wr(9'h07F, 8'hE3);
      run_copy(3, nb, nd, ds);
      check("rst_copy_busy_cycles", 24'(nb), 24'd60);
      check("rst_copy_no_done", 24'(nd), 24'd0);
      spat_rd("rst_entry0_new", 7'd0, 24'hC35AE0);
      spat_rd("rst_entry58_new", 7'd58, 24'hF960E1);
      spat_rd("rst_entry60_old", 7'd60, 24'hFF663C);
      spat_rd("rst_entry127_old", 7'd127, 24'hBC257F);

      cpu_wr(9'h014, 8'hE4);
      run_copy(4, nb, nd, ds);
      check("copy5_busy_cycles", 24'(nb), 24'd129);
      check("copy5_done_count", 24'(nd), 24'd1);
      spat_rd("copy5_entry60", 7'd60, 24'hFF66E2);
      spat_rd("copy5_entry127", 7'd127, 24'hBC25E3);

      // Same-cycle CPU read and write returns the old byte.
      CPUAD = 9'h006;
      CPUDI = 8'h77;
      CPUWE = 1'b1;
      tick();
      CPUWE = 1'b0;
      check("cpu_read_first_old", {16'h0, CPUDO}, 24'h000006);
      cpu_rd("cpu_read_first_new", 9'h006, 8'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
